// File: rtl/dm_access_unit_pkg.sv
// Shared encodings and helpers for the data-memory access unit:
// op types, FSM states, the data-memory address limit and lane helpers.
package dm_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DM_LIMIT = 32'h0000_3000;

    function automatic logic op_is_store(input op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic op_misaligned(input op_t op, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:          bad = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH:  bad = lo[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] op_byte_enables(input op_t op, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b1111;
        case (op)
            OP_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
            OP_SB:   be = 4'b0001 << lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store source across every lane it could land in so the
    // byte enables alone select the written bytes.
    function automatic logic [31:0] op_lane_wdata(input op_t op, input logic [31:0] data);
        logic [31:0] lanes;
        lanes = data;
        case (op)
            OP_SH:   lanes = {2{data[15:0]}};
            OP_SB:   lanes = {4{data[7:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load-result extraction: picks the addressed halfword/byte out of the raw
// memory word and sign- or zero-extends it according to the load type.
module dm_load_ext
    import dm_access_unit_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic signed [15:0] half;
    logic signed [7:0]  byte_sel;

    always_comb begin
        half     = lo[1] ? word[31:16] : word[15:0];
        byte_sel = word[7:0];
        case (lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        data = word;
        case (op)
            OP_LH:   data = {{16{half[15]}}, half};
            OP_LHU:  data = {16'h0000, half};
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h00_0000, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// M-stage data-memory access unit: address checks, one-request handshake
// with the data memory, and extended load results with a completion pulse.
module dm_access_unit
    import dm_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    op_t         op_r;
    logic [1:0]  lo_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;

    op_t         op_in;
    logic        store_in;
    logic        bad_in;
    logic        idle_op;
    logic        accept;
    logic [31:0] ext_data;

    assign op_in    = op_t'(op_type);
    assign store_in = op_is_store(op_in);
    assign bad_in   = op_misaligned(op_in, addr[1:0]) || (addr >= DM_LIMIT);
    // Combinational IDLE decisions are gated by reset so every output is
    // low while reset is held, even with op_valid asserted.
    assign idle_op  = reset && (state == ST_IDLE) && op_valid;
    assign accept   = idle_op && !bad_in;

    dm_load_ext u_load_ext (
        .op   (op_r),
        .lo   (lo_r),
        .word (mem_rdata),
        .data (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_r    <= OP_LW;
            lo_r    <= 2'b00;
            we_r    <= 1'b0;
            addr_r  <= 32'h0;
            be_r    <= 4'h0;
            wdata_r <= 32'h0;
            rdata_r <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r    <= op_in;
                        lo_r    <= addr[1:0];
                        we_r    <= store_in;
                        addr_r  <= {addr[31:2], 2'b00};
                        be_r    <= op_byte_enables(op_in, addr[1:0]);
                        wdata_r <= op_lane_wdata(op_in, wdata);
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!we_r) begin
                            rdata_r <= ext_data;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall       = accept || (state == ST_REQ);
    assign exc_adel    = idle_op && bad_in && !store_in;
    assign exc_ades    = idle_op && bad_in && store_in;
    assign mem_req     = (state == ST_REQ);
    assign mem_we      = (state == ST_REQ) && we_r;
    assign mem_addr    = addr_r;
    assign mem_be      = be_r;
    assign mem_wdata   = wdata_r;
    assign rdata       = rdata_r;
    assign rdata_valid = (state == ST_DONE);

endmodule
